// File: rtl/cast_float_to_int_pipe_if.sv
// Operand/result bundle for the float-to-int cast unit.
// Carries the input handshake with operand and mode, and the output handshake with result and flags.
// The master modport belongs to the producer/consumer side and the slave modport to the converter.
interface cast_float_to_int_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        invalid;
  logic        inexact;

  modport master (
    output in_valid, in, is_signed, out_ready,
    input  in_ready, out_valid, out, invalid, inexact
  );

  modport slave (
    input  in_valid, in, is_signed, out_ready,
    output in_ready, out_valid, out, invalid, inexact
  );
endinterface

// File: rtl/cast_float_to_int_pipe.sv
// IEEE-754 single to 32-bit signed/unsigned integer cast: truncate toward zero, saturate, invalid/inexact flags.
// Latency 2 cycles (decode register, then shift/saturate register); one result per cycle.
// Backpressure: each stage advances when the next is empty or draining; in_ready is combinational from out_ready.
module cast_float_to_int_pipe #(
  parameter logic [31:0] NAN_VALUE = 32'h0000_0000
) (
  input logic clk,
  input logic clr,
  cast_float_to_int_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_SMALL  = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } cls_t;

  // ---------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------
  logic s1_vld_q;
  logic s2_vld_q;
  logic s1_adv;

  assign s1_adv       = !s2_vld_q || bus.out_ready;
  assign bus.in_ready = !s1_vld_q || s1_adv;

  // ---------------------------------------------------------------
  // S1 decode (combinational from the operand)
  // ---------------------------------------------------------------
  logic [7:0]  e_w;
  logic [22:0] f_w;
  cls_t        cls_d;
  logic        big_d;
  logic        left_d;
  logic [4:0]  rsh_d;
  logic [3:0]  lsh_d;

  assign e_w    = bus.in[30:23];
  assign f_w    = bus.in[22:0];
  // k = e-127 >= 32 means the magnitude cannot fit in 32 bits
  assign big_d  = (e_w >= 8'd159);
  // 23 < k: the significand must move left rather than right
  assign left_d = (e_w > 8'd150);
  assign rsh_d  = 5'(8'd150 - e_w);
  assign lsh_d  = 4'(e_w - 8'd150);

  // Classify the operand by exponent/fraction
  always_comb begin
    cls_d = CLS_NORMAL;
    if (e_w == 8'hFF) begin
      cls_d = (f_w != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (e_w < 8'd127) begin
      cls_d = CLS_SMALL;
    end
  end

  logic        s1_s_q;
  cls_t        s1_cls_q;
  logic [23:0] s1_sig_q;
  logic        s1_signed_q;
  logic        s1_big_q;
  logic        s1_left_q;
  logic [4:0]  s1_rsh_q;
  logic [3:0]  s1_lsh_q;
  logic        s1_nz_q;

  // S1 register: capture the decoded operand on an input transfer
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_vld_q    <= 1'b0;
      s1_s_q      <= 1'b0;
      s1_cls_q    <= CLS_NORMAL;
      s1_sig_q    <= '0;
      s1_signed_q <= 1'b0;
      s1_big_q    <= 1'b0;
      s1_left_q   <= 1'b0;
      s1_rsh_q    <= '0;
      s1_lsh_q    <= '0;
      s1_nz_q     <= 1'b0;
    end else if (bus.in_ready) begin
      s1_vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_s_q      <= bus.in[31];
        s1_cls_q    <= cls_d;
        s1_sig_q    <= {1'b1, f_w};
        s1_signed_q <= bus.is_signed;
        s1_big_q    <= big_d;
        s1_left_q   <= left_d;
        s1_rsh_q    <= rsh_d;
        s1_lsh_q    <= lsh_d;
        s1_nz_q     <= (bus.in[30:0] != 31'd0);
      end
    end
  end

  // ---------------------------------------------------------------
  // S2 shift / saturate (combinational from S1)
  // ---------------------------------------------------------------
  logic [31:0] mag_w;
  logic        lost_w;
  logic        ovf_w;
  logic [31:0] res_d;
  logic        inv_d;
  logic        inx_d;

  assign ovf_w = (s1_cls_q == CLS_INF) || s1_big_q;

  // Align the significand to the integer point and collect the dropped bits
  always_comb begin
    mag_w  = '0;
    lost_w = 1'b0;
    if (s1_cls_q == CLS_SMALL) begin
      lost_w = s1_nz_q;
    end else if (s1_left_q) begin
      mag_w = {8'd0, s1_sig_q} << s1_lsh_q;
    end else begin
      mag_w  = {8'd0, s1_sig_q >> s1_rsh_q};
      lost_w = |(s1_sig_q & ~(24'hFF_FFFF << s1_rsh_q));
    end
  end

  // Pick the result: NaN first, then saturation per signedness, then the truncated value
  always_comb begin
    res_d = mag_w;
    inv_d = 1'b0;
    if (s1_cls_q == CLS_NAN) begin
      res_d = NAN_VALUE;
      inv_d = 1'b1;
    end else if (s1_signed_q) begin
      if (!s1_s_q && (ovf_w || mag_w[31])) begin
        res_d = 32'h7FFF_FFFF;
        inv_d = 1'b1;
      end else if (s1_s_q && (ovf_w || (mag_w[31] && (mag_w[30:0] != 31'd0)))) begin
        res_d = 32'h8000_0000;
        inv_d = 1'b1;
      end else begin
        res_d = s1_s_q ? (32'd0 - mag_w) : mag_w;
      end
    end else begin
      if (!s1_s_q && ovf_w) begin
        res_d = 32'hFFFF_FFFF;
        inv_d = 1'b1;
      end else if (s1_s_q && (ovf_w || (mag_w != 32'd0))) begin
        res_d = 32'd0;
        inv_d = 1'b1;
      end
    end
    inx_d = lost_w && !inv_d;
  end

  logic [31:0] out_q;
  logic        inv_q;
  logic        inx_q;

  // S2 register: load when downstream is empty or draining, otherwise hold the result stable
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s2_vld_q <= 1'b0;
      out_q    <= '0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else if (s1_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_q <= res_d;
        inv_q <= inv_d;
        inx_q <= inx_d;
      end
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.out       = out_q;
  assign bus.invalid   = inv_q;
  assign bus.inexact   = inx_q;

endmodule
